ps2_note_decoder: RTL

- Upstream of the speaker tone generator. Receives raw PS/2 keyboard frames, decodes make, break and extended scancodes, and maps piano keys to the 6-bit note code that the tone generator consumes.
- Tracks the most recently pressed piano key and holds its code on `note` until that key is released, then outputs the stop code 6'b111111.
- Single clock domain, 100 MHz system clock; ps2_clk and ps2_data are asynchronous inputs.

---
 rtl/ps2_note_decoder_pkg.sv | 57 +++++
 rtl/ps2_note_decoder_rx.sv | 104 ++++++++++
 rtl/ps2_note_decoder.sv | 77 +++++++
 3 files changed

// File: rtl/ps2_note_decoder_pkg.sv
// Shared constants for the PS/2 piano-key decoder: note codes, scancodes,
// the scancode-to-note map and the decoder FSM state encoding.
// Ports: none (package). Latency/backpressure: not applicable.
package ps2_note_pkg;

   localparam logic [5:0] NOTE_STOP = 6'b111111;
   localparam logic [5:0] NOTE_C4   = 6'd11;
   localparam logic [5:0] NOTE_CS4  = 6'd12;
   localparam logic [5:0] NOTE_D4   = 6'd13;
   localparam logic [5:0] NOTE_DS4  = 6'd14;
   localparam logic [5:0] NOTE_E4   = 6'd15;
   localparam logic [5:0] NOTE_F4   = 6'd16;
   localparam logic [5:0] NOTE_FS4  = 6'd17;
   localparam logic [5:0] NOTE_G4   = 6'd18;
   localparam logic [5:0] NOTE_GS4  = 6'd19;
   localparam logic [5:0] NOTE_A4   = 6'd20;
   localparam logic [5:0] NOTE_AS4  = 6'd21;
   localparam logic [5:0] NOTE_B4   = 6'd22;
   localparam logic [5:0] NOTE_C5   = 6'd23;
   localparam logic [5:0] NOTE_CS5  = 6'd24;
   localparam logic [5:0] NOTE_D5   = 6'd25;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BREAK  = 2'd1,
      S_EXT    = 2'd2,
      S_EXTBRK = 2'd3
   } state_t;

   // Unmapped scancodes return NOTE_STOP so callers can test "is mapped".
   function automatic logic [5:0] note_map(input logic [7:0] code);
      logic [5:0] n;
      case (code)
         8'h1C:   n = NOTE_C4;
         8'h1D:   n = NOTE_CS4;
         8'h1B:   n = NOTE_D4;
         8'h24:   n = NOTE_DS4;
         8'h23:   n = NOTE_E4;
         8'h2B:   n = NOTE_F4;
         8'h2C:   n = NOTE_FS4;
         8'h34:   n = NOTE_G4;
         8'h35:   n = NOTE_GS4;
         8'h33:   n = NOTE_A4;
         8'h3C:   n = NOTE_AS4;
         8'h3B:   n = NOTE_B4;
         8'h42:   n = NOTE_C5;
         8'h44:   n = NOTE_CS5;
         8'h4B:   n = NOTE_D5;
         default: n = NOTE_STOP;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ps2_note_decoder_rx.sv
// PS/2 frame receiver: 2-FF sync, ps2_clk stability filter, 11-bit shifter, parity/start/stop check, timeout.
// Latency: byte_valid rises FILT+3 clk cycles after the stop-bit falling edge on the pin.
// Backpressure: none; byte_valid and frame_err are single-cycle strobes with no hold-off.
// Ports: clk, rst (async active-high), ps2_clk/ps2_data (async pins),
//        rx_byte (last good byte), byte_valid (good-byte strobe), frame_err (error strobe).
module ps2_rx #(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    sr;
   logic [TW-1:0] timer;
   logic          good;

   // Synchronizer and glitch filter. Lines idle high, so reset to 1 to avoid
   // a spurious falling edge straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILT - 1)) begin
            // New level has now been seen for FILT consecutive cycles.
            clk_filt <= clk_s2;
            filt_cnt <= '0;
            fall     <= ~clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // sr fills from the top: after ten shifts sr[0]=start, sr[8:1]=data, sr[9]=parity.
   // The stop bit is taken live from dat_s2 on the eleventh edge.
   assign good = ~sr[0] & dat_s2 & (^sr[9:1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt    <= '0;
         sr         <= '0;
         timer      <= '0;
         rx_byte    <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall) begin
            timer <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (good) begin
                  rx_byte    <= sr[8:1];
                  byte_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               sr      <= {dat_s2, sr[9:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (bit_cnt != 4'd0) begin
            if (timer == TW'(TIMEOUT - 1)) begin
               frame_err <= 1'b1;
               bit_cnt   <= '0;
               timer     <= '0;
            end else begin
               timer <= timer + 1'b1;
            end
         end else begin
            timer <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_note_decoder.sv
// Decodes PS/2 make/break/extended scancodes into the 6-bit note code for the tone generator.
// Latency: note/key_down update exactly one clk cycle after byte_valid.
// Backpressure: none; every received byte is consumed in the cycle it is strobed.
// Ports: clk, rst (async active-high), ps2_clk/ps2_data (async pins), note (111111 = silence),
//        key_down (note valid), byte_valid/rx_byte (received byte), frame_err (error strobe).
module ps2_note_decoder
   import ps2_note_pkg::*;
#(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [5:0] note,
   output logic       key_down,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   state_t     state;
   logic [5:0] code_note;

   ps2_rx #(
      .FILT    (FILT),
      .TIMEOUT (TIMEOUT)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign code_note = note_map(rx_byte);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         note     <= NOTE_STOP;
         key_down <= 1'b0;
      end else if (byte_valid) begin
         case (state)
            S_IDLE: begin
               if (rx_byte == SC_BREAK) begin
                  state <= S_BREAK;
               end else if (rx_byte == SC_EXT) begin
                  state <= S_EXT;
               end else if (code_note != NOTE_STOP) begin
                  // Last press wins; a typematic repeat rewrites the same value.
                  note     <= code_note;
                  key_down <= 1'b1;
               end
            end
            S_BREAK: begin
               state <= S_IDLE;
               // Only releasing the key currently sounding silences the output.
               if (code_note != NOTE_STOP && code_note == note) begin
                  note     <= NOTE_STOP;
                  key_down <= 1'b0;
               end
            end
            S_EXT: begin
               state <= (rx_byte == SC_BREAK) ? S_EXTBRK : S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
